buffer_memory_commit: RTL and testbench

BUFFER_MEMORY_COMMIT -- requirements
Module: buffer_memory_commit

---
 rtl/buffer_memory_commit.sv | 121 ++++++++++++
 tb/tb_buffer_memory_commit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_memory_commit.sv
// buffer_memory_commit
//   FIFO-style buffer with a speculative write side. Words are written
//   speculatively and become readable only after a commit. A discard throws
//   away every word written since the last commit.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   reset      synchronous, active-high; overrides every other input
//   data_in    write word
//   wr_en      speculative write request
//   commit     publish all speculative words (includes a same-cycle write)
//   discard    drop all uncommitted words (wins over commit)
//   rd_en      read request
//   data_out   registered read word, held when no read is accepted
//   out_valid  data_out holds the word from the previous cycle's accepted read
//   data_av    at least one committed, unread word
//   full       committed + uncommitted words == DEPTH
//   empty      no stored words at all
//   level      committed unread word count
//   overflow   one-cycle pulse: write refused because the buffer was full
//   underflow  one-cycle pulse: read refused because nothing was committed
//
// Handshake semantics: a write is taken on a rising edge when wr_en=1,
// full=0 and discard=0 (full is the pre-edge value). A read is taken on a
// rising edge when rd_en=1 and data_av=1; its word appears on data_out with
// out_valid=1 during the following cycle. A refused request is not retried by
// the block; it only raises overflow/underflow for one cycle.

module buffer_memory_commit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  commit,
  input  logic                  discard,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  data_av,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;

  // Pointers carry one extra wrap bit so that full and empty are
  // distinguishable; they wrap naturally modulo 2*DEPTH.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] cm_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] used;
  logic             wr_fire;
  logic             rd_fire;
  logic [PTR_W-1:0] wr_ptr_next;

  assign used    = wr_ptr - rd_ptr;
  assign level   = cm_ptr - rd_ptr;
  assign full    = (used == PTR_W'(DEPTH));
  assign empty   = (used == '0);
  assign data_av = (level != '0);

  // A discard in the same cycle drops the write outright, so it neither
  // stores nor counts as an overflow.
  assign wr_fire = wr_en && !full && !discard;
  assign rd_fire = rd_en && data_av;

  always_comb begin
    wr_ptr_next = wr_ptr;
    if (discard) begin
      wr_ptr_next = cm_ptr;
    end else if (wr_fire) begin
      wr_ptr_next = wr_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_next;
      // Commit captures the post-edge write pointer, so a same-cycle write
      // is published too. Discard wins and leaves cm_ptr alone.
      if (commit && !discard) begin
        cm_ptr <= wr_ptr_next;
      end
      if (rd_fire) begin
        data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      out_valid <= rd_fire;
      overflow  <= wr_en && full && !discard;
      underflow <= rd_en && !data_av;
    end
  end

  // Storage array: no reset, one write port and one read port. The read
  // slot is always committed and the write slot never is, so the two ports
  // never touch the same word in one cycle.
  always_ff @(posedge clk) begin
    if (wr_fire && !reset) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_buffer_memory_commit.sv
// Testbench for buffer_memory_commit (DATA_WIDTH=32, ADDR_WIDTH=2).
// Stimulus pushes the expected read word into exp_q whenever it issues a read
// that must be accepted; a monitor pops and compares whenever out_valid is
// seen. Flags and counts are checked directly after each edge.

module tb_buffer_memory_commit;

  localparam int DW = 32;
  localparam int AW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] data_in = '0;
  logic          wr_en = 1'b0;
  logic          commit = 1'b0;
  logic          discard = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          data_av;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          underflow;

  buffer_memory_commit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .commit    (commit),
    .discard   (discard),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .out_valid (out_valid),
    .data_av   (data_av),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: out_valid is stable between rising edges, so sample on negedge.
  always @(negedge clk) begin
    if (!done && out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %h expected no out_valid", data_out);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL read_data: got %h expected %h", data_out, e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver ----------------
  // Apply one cycle of inputs, wait for the edge, then release them. On
  // return the outputs reflect the state after that edge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic c,
                       input logic dc, input logic r);
    wr_en   = w;
    data_in = d;
    commit  = c;
    discard = dc;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    commit  = 1'b0;
    discard = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_flags(input string tag, input logic f, input logic e,
                             input logic av, input int lv);
    check({tag, "_full"},  DW'(full),  DW'(f));
    check({tag, "_empty"}, DW'(empty), DW'(e));
    check({tag, "_av"},    DW'(data_av), DW'(av));
    check({tag, "_level"}, DW'(level), DW'(lv));
  endtask

  logic [DW-1:0] words [4];

  initial begin
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;
    words[3] = 32'h4444_4444;

    // Reset state
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    check_flags("reset", 1'b0, 1'b1, 1'b0, 0);
    check("reset_data_out", data_out, '0);
    check("reset_out_valid", DW'(out_valid), '0);
    check("reset_overflow", DW'(overflow), '0);
    check("reset_underflow", DW'(underflow), '0);

    // Uncommitted words are not readable
    cycle(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hBBBB_BBBB, 1'b0, 1'b0, 1'b0);
    check_flags("spec2", 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("uf_pulse", DW'(underflow), 1);
    check("uf_no_valid", DW'(out_valid), 0);
    check("uf_level", DW'(level), 0);
    idle();
    check("uf_clear", DW'(underflow), 0);

    // Commit then read both back
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_flags("commit2", 1'b0, 1'b0, 1'b1, 2);
    exp_q.push_back(32'hAAAA_AAAA);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("rd1_level", DW'(level), 1);
    check("rd1_valid", DW'(out_valid), 1);
    exp_q.push_back(32'hBBBB_BBBB);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_flags("rd2", 1'b0, 1'b1, 1'b0, 0);
    idle();
    check("hold_data", data_out, 32'hBBBB_BBBB);
    check("hold_valid", DW'(out_valid), 0);

    // Fill to full, overflow, commit, drain across pointer wrap
    for (int i = 0; i < 4; i++) cycle(1'b1, words[i], 1'b0, 1'b0, 1'b0);
    check_flags("full4", 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
    check("ovf_pulse", DW'(overflow), 1);
    check("ovf_full", DW'(full), 1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("ovf_clear", DW'(overflow), 0);
    check("full_uncommitted_uf", DW'(underflow), 1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_flags("commit4", 1'b1, 1'b0, 1'b1, 4);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(words[i]);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("drain_level", DW'(level), DW'(3 - i));
    end
    check_flags("drained", 1'b0, 1'b1, 1'b0, 0);

    // Discard drops only uncommitted words
    cycle(1'b1, 32'hC1C1_C1C1, 1'b1, 1'b0, 1'b0);
    check("wc_level", DW'(level), 1);
    cycle(1'b1, 32'hD1D1_D1D1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hD2D2_D2D2, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_flags("discard", 1'b0, 1'b0, 1'b1, 1);
    exp_q.push_back(32'hC1C1_C1C1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_flags("discard_rd", 1'b0, 1'b1, 1'b0, 0);

    // wr + commit + discard together: word dropped, commit ignored
    cycle(1'b1, 32'hF0F0_F0F0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hEEEE_EEEE, 1'b1, 1'b1, 1'b0);
    check_flags("wcd", 1'b0, 1'b1, 1'b0, 0);
    check("wcd_ovf", DW'(overflow), 0);
    // Write while full with discard: no overflow
    for (int i = 0; i < 4; i++) cycle(1'b1, words[i], 1'b0, 1'b0, 1'b0);
    check("pre_disc_full", DW'(full), 1);
    cycle(1'b1, 32'h7777_7777, 1'b0, 1'b1, 1'b0);
    check("full_disc_ovf", DW'(overflow), 0);
    check_flags("full_disc", 1'b0, 1'b1, 1'b0, 0);

    // Streaming: write+commit+read every cycle
    cycle(1'b1, 32'h5000_0000, 1'b1, 1'b0, 1'b0);
    check("prime_level", DW'(level), 1);
    for (int i = 1; i <= 11; i++) begin
      exp_q.push_back(32'h5000_0000 + DW'(i - 1));
      cycle(1'b1, 32'h5000_0000 + DW'(i), 1'b1, 1'b0, 1'b1);
      check("stream_level", DW'(level), 1);
      check("stream_ovf", DW'(overflow), 0);
      check("stream_uf", DW'(underflow), 0);
    end

    // Reset mid-stream overrides everything
    reset = 1'b1;
    cycle(1'b1, 32'h9999_9999, 1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    check_flags("midrst", 1'b0, 1'b1, 1'b0, 0);
    check("midrst_data", data_out, '0);
    check("midrst_valid", DW'(out_valid), 0);
    check("midrst_ovf", DW'(overflow), 0);
    check("midrst_uf", DW'(underflow), 0);

    idle();
    idle();
    check("exp_q_empty", DW'(exp_q.size()), 0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
